switch_nport: RTL and testbench

Parametrised N-port address-routed packet switch; successor to the two-port `switch`. One input stream of (addr, data) packets is routed to one of `NUM_PORTS` output streams by address, or replicated to all ports when broadcast is enabled. Each output has its own FIFO. Valid/ready handshakes on every interface provide backpressure instead of silently losing packets. It sits between the stimulus/driver side and per-port consumers, in the same `switch_if`-driven environment.

---
 rtl/switch_pkg.sv | 22 ++
 rtl/switch_fifo.sv | 59 +++++
 rtl/switch_nport.sv | 93 +++++++++
 tb/tb_switch_nport.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared helpers for the N-port packet switch: port-index width and broadcast detection.
package switch_pkg;

   // Upper bound on the address width that is_bcast can inspect.
   localparam int MAX_ADDR_W = 64;

   // Width of a port index for n output ports.
   function automatic int port_w(input int n);
      return $clog2(n);
   endfunction

   // True when the low addrW bits of addr are all ones, i.e. the broadcast address.
   function automatic logic is_bcast(input logic [MAX_ADDR_W-1:0] addr, input int addrW);
      logic allOnes;
      allOnes = 1'b1;
      for (int i = 0; i < MAX_ADDR_W; i++) begin
         if ((i < addrW) && !addr[i]) allOnes = 1'b0;
      end
      return allOnes;
   endfunction

endpackage

// File: rtl/switch_fifo.sv
// First-word-fall-through FIFO used once per switch output port.
module switch_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             doPush, doPop;

   // Guard the handshakes locally so an illegal push/pop can never corrupt state.
   assign doPush = push && !full;
   assign doPop  = pop && !empty;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign dout  = mem_q[rdPtr_q];

   // Occupancy changes by one on a lone push or pop; a simultaneous pair leaves it unchanged.
   always_comb begin
      count_d = count_q;
      case ({doPush, doPop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer, count and storage registers; storage is cleared so the head reads zero after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         count_q <= count_d;
         if (doPush) begin
            mem_q[wrPtr_q] <= din;
            wrPtr_q        <= wrPtr_q + PTR_W'(1);
         end
         if (doPop) rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
   end

endmodule

// File: rtl/switch_nport.sv
// Address-routed packet switch: one input stream fanned out to NUM_PORTS FIFO-buffered outputs.
module switch_nport
   import switch_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 16,
   parameter int NUM_PORTS  = 4,
   parameter int FIFO_DEPTH = 4,
   parameter bit BCAST_EN   = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_vld,
   output logic                      in_rdy,
   input  logic [ADDR_W-1:0]         in_addr,
   input  logic [DATA_W-1:0]         in_data,
   output logic [NUM_PORTS-1:0]      out_vld,
   input  logic [NUM_PORTS-1:0]      out_rdy,
   output logic [NUM_PORTS*ADDR_W-1:0] out_addr,
   output logic [NUM_PORTS*DATA_W-1:0] out_data,
   output logic [NUM_PORTS*16-1:0]   pkt_cnt
);

   localparam int PORT_W = port_w(NUM_PORTS);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } pkt_t;

   logic [PORT_W-1:0]    dest;
   logic                 bcast;
   logic [NUM_PORTS-1:0] target;
   logic [NUM_PORTS-1:0] fullVec;
   logic [NUM_PORTS-1:0] emptyVec;
   logic [NUM_PORTS-1:0] pushVec;
   logic [NUM_PORTS-1:0] popVec;
   logic                 accept;
   pkt_t                 inPkt;
   pkt_t                 headPkt [NUM_PORTS];
   logic [15:0]          cnt_q [NUM_PORTS];

   assign dest  = in_addr[ADDR_W-1 -: PORT_W];
   assign bcast = BCAST_EN && is_bcast(MAX_ADDR_W'(in_addr), ADDR_W);
   assign inPkt = '{addr: in_addr, data: in_data};

   // Route decode and ready: broadcast needs every FIFO to have room, unicast only its own.
   always_comb begin
      target = '0;
      if (bcast) begin
         target = '1;
         in_rdy = ~|fullVec;
      end else begin
         target[dest] = 1'b1;
         in_rdy       = !fullVec[dest];
      end
   end

   assign accept  = in_vld && in_rdy;
   assign pushVec = accept ? target : '0;
   assign out_vld = ~emptyVec;
   assign popVec  = out_vld & out_rdy;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      switch_fifo #(
         .WIDTH ($bits(pkt_t)),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (pushVec[p]),
         .din   (inPkt),
         .full  (fullVec[p]),
         .pop   (popVec[p]),
         .dout  (headPkt[p]),
         .empty (emptyVec[p])
      );

      assign out_addr[p*ADDR_W +: ADDR_W] = headPkt[p].addr;
      assign out_data[p*DATA_W +: DATA_W] = headPkt[p].data;
      assign pkt_cnt[p*16 +: 16]          = cnt_q[p];

      // Per-port accepted-packet counter, wrapping at 0xFFFF.
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_q[p] <= '0;
         end else if (pushVec[p]) begin
            cnt_q[p] <= cnt_q[p] + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_switch_nport.sv
// Directed self-checking bench for switch_nport with default parameters.
module tb_switch_nport;

   logic        clk;
   logic        rst;
   logic        in_vld;
   logic        in_rdy;
   logic [7:0]  in_addr;
   logic [15:0] in_data;
   logic [3:0]  out_vld;
   logic [3:0]  out_rdy;
   logic [31:0] out_addr;
   logic [63:0] out_data;
   logic [63:0] pkt_cnt;

   int testsRun  = 0;
   int failCount = 0;

   switch_nport #(
      .ADDR_W     (8),
      .DATA_W     (16),
      .NUM_PORTS  (4),
      .FIFO_DEPTH (4),
      .BCAST_EN   (1'b1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (in_vld),
      .in_rdy   (in_rdy),
      .in_addr  (in_addr),
      .in_data  (in_data),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .out_addr (out_addr),
      .out_data (out_data),
      .pkt_cnt  (pkt_cnt)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] dataOf(input int p);
      return out_data[p*16 +: 16];
   endfunction

   function automatic logic [15:0] cntOf(input int p);
      return pkt_cnt[p*16 +: 16];
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testsRun++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic vld, input logic [7:0] addr, input logic [15:0] data);
      in_vld  = vld;
      in_addr = addr;
      in_data = data;
   endtask

   // Advance past one rising edge and settle 1 time unit after it.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(1'b0, 8'h00, 16'h0000);
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      out_rdy = 4'h0;
      applyStimulus(1'b0, 8'h00, 16'h0000);
      cycle();
      cycle();
      rst = 1'b0;

      // Reset state
      checkOutput("reset_in_rdy", in_rdy, 1'b1);
      checkOutput("reset_out_vld", out_vld, 4'h0);
      checkOutput("reset_pkt_cnt", pkt_cnt, 64'h0);
      checkOutput("reset_out_data", out_data, 64'h0);

      // First packet after reset goes only to port 1
      out_rdy = 4'hF;
      applyStimulus(1'b1, 8'h45, 16'h1234);
      checkOutput("first_in_rdy", in_rdy, 1'b1);
      cycle();
      applyStimulus(1'b0, 8'h00, 16'h0000);
      checkOutput("first_out_vld", out_vld, 4'b0010);
      checkOutput("first_data", dataOf(1), 16'h1234);
      checkOutput("first_addr", out_addr[15:8], 8'h45);
      checkOutput("first_cnt", pkt_cnt, 64'h0000_0000_0001_0000);
      cycle();
      checkOutput("first_drained", out_vld, 4'h0);

      // Routing sweep across address-range boundaries
      doReset();
      out_rdy = 4'h0;
      applyStimulus(1'b1, 8'h00, 16'h1000); cycle();
      applyStimulus(1'b1, 8'h7F, 16'h1001); cycle();
      applyStimulus(1'b1, 8'h80, 16'h1002); cycle();
      applyStimulus(1'b1, 8'hC0, 16'h1003); cycle();
      applyStimulus(1'b0, 8'h00, 16'h0000);
      checkOutput("sweep_out_vld", out_vld, 4'hF);
      for (int p = 0; p < 4; p++) begin
         checkOutput($sformatf("sweep_data_p%0d", p), dataOf(p), 16'h1000 + 16'(p));
      end
      checkOutput("sweep_cnt", pkt_cnt, 64'h0001_0001_0001_0001);
      out_rdy = 4'hF;
      cycle();
      checkOutput("sweep_drained", out_vld, 4'h0);

      // Backpressure on port 2
      doReset();
      out_rdy = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'h90, 16'h2000 + 16'(i));
         checkOutput($sformatf("bp_in_rdy_%0d", i), in_rdy, 1'b1);
         cycle();
      end
      applyStimulus(1'b1, 8'h90, 16'h2004);
      checkOutput("bp_full_in_rdy", in_rdy, 1'b0);
      out_rdy = 4'hF;
      #1;
      checkOutput("bp_no_comb_path", in_rdy, 1'b0);
      checkOutput("bp_head0", dataOf(2), 16'h2000);
      cycle();
      checkOutput("bp_reenabled", in_rdy, 1'b1);
      checkOutput("bp_head1", dataOf(2), 16'h2001);
      cycle();
      applyStimulus(1'b0, 8'h00, 16'h0000);
      for (int k = 2; k <= 4; k++) begin
         checkOutput($sformatf("bp_vld_%0d", k), out_vld[2], 1'b1);
         checkOutput($sformatf("bp_order_%0d", k), dataOf(2), 16'h2000 + 16'(k));
         cycle();
      end
      checkOutput("bp_empty", out_vld[2], 1'b0);
      checkOutput("bp_cnt", cntOf(2), 16'd5);

      // Broadcast, then all-or-nothing with port 0 full
      doReset();
      out_rdy = 4'h0;
      applyStimulus(1'b1, 8'hFF, 16'hBEEF);
      checkOutput("bc_in_rdy", in_rdy, 1'b1);
      cycle();
      applyStimulus(1'b0, 8'h00, 16'h0000);
      checkOutput("bc_out_vld", out_vld, 4'hF);
      for (int p = 0; p < 4; p++) begin
         checkOutput($sformatf("bc_data_p%0d", p), dataOf(p), 16'hBEEF);
      end
      checkOutput("bc_cnt", pkt_cnt, 64'h0001_0001_0001_0001);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 8'h10, 16'h3000 + 16'(i));
         cycle();
      end
      applyStimulus(1'b1, 8'hFF, 16'hDEAD);
      #1;
      checkOutput("bc_blocked", in_rdy, 1'b0);
      applyStimulus(1'b1, 8'h40, 16'h4000);
      #1;
      checkOutput("bc_unicast_ok", in_rdy, 1'b1);
      cycle();
      applyStimulus(1'b0, 8'h00, 16'h0000);
      checkOutput("bc_cnt_after", pkt_cnt, 64'h0001_0001_0002_0004);

      // Continuous stream through port 3 across pointer wrap
      doReset();
      out_rdy = 4'hF;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 8'hC5, 16'h5000 + 16'(i));
         checkOutput($sformatf("wrap_in_rdy_%0d", i), in_rdy, 1'b1);
         cycle();
         checkOutput($sformatf("wrap_vld_%0d", i), out_vld, 4'b1000);
         checkOutput($sformatf("wrap_data_%0d", i), dataOf(3), 16'h5000 + 16'(i));
      end
      applyStimulus(1'b0, 8'h00, 16'h0000);
      cycle();
      checkOutput("wrap_empty", out_vld, 4'h0);
      checkOutput("wrap_cnt", cntOf(3), 16'd10);

      // Mid-stream reset flushes queued packets; accept during reset is ignored
      doReset();
      out_rdy = 4'h0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 8'h50, 16'h6000 + 16'(i));
         cycle();
      end
      checkOutput("mr_queued", out_vld, 4'b0010);
      rst = 1'b1;
      applyStimulus(1'b1, 8'h50, 16'h6FFF);
      cycle();
      rst = 1'b0;
      applyStimulus(1'b0, 8'h00, 16'h0000);
      checkOutput("mr_out_vld", out_vld, 4'h0);
      checkOutput("mr_pkt_cnt", pkt_cnt, 64'h0);
      checkOutput("mr_out_data", out_data, 64'h0);
      out_rdy = 4'hF;
      cycle();
      cycle();
      checkOutput("mr_no_stale", out_vld, 4'h0);
      applyStimulus(1'b1, 8'h51, 16'h7777);
      cycle();
      applyStimulus(1'b0, 8'h00, 16'h0000);
      checkOutput("mr_fresh_vld", out_vld, 4'b0010);
      checkOutput("mr_fresh_data", dataOf(1), 16'h7777);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
